// File: rtl/host_param_seq_if.sv
// 8080-style host write bus: chip select, address, write strobe and data.
// The host drives the master side; the sequencer samples the slave side.
interface host_param_seq_if #(
    parameter int unsigned DW = 8
);
    logic          ce_x;
    logic          a0;
    logic          wr_x;
    logic [DW-1:0] dat;

    modport master (output ce_x, a0, wr_x, dat);
    modport slave  (input  ce_x, a0, wr_x, dat);
endinterface

// File: rtl/host_param_seq.sv
// Host command/parameter sequencer: synchronises the async host write bus, decodes
// commands and parameter writes, and fills an NREG-deep parameter register file.
module host_param_seq #(
    parameter int unsigned   DW       = 8,
    parameter int unsigned   NREG     = 8,
    parameter int unsigned   RIW      = 3,
    parameter logic [DW-1:0] CMD_BASE = DW'(8'h40)
) (
    input  logic                 clk,
    input  logic                 rst,
    host_param_seq_if.slave      host,
    output logic                 cmd_vld,
    output logic [DW-1:0]        cmd_code,
    output logic                 reg_we,
    output logic [RIW-1:0]       reg_idx,
    output logic [DW-1:0]        reg_wdata,
    output logic                 seq_done,
    output logic                 seq_err,
    output logic [NREG*DW-1:0]   reg_flat
);

    typedef enum logic [0:0] {StIdle, StParam} state_e;

    logic          wr_s1_q, wr_s1_d, s_wr_q, s_wr_d, wr_prev_q, wr_prev_d;
    logic          a0_s1_q, a0_s1_d, s_a0_q, s_a0_d, cap_a0_q, cap_a0_d;
    logic [DW-1:0] dat_s1_q, dat_s1_d, s_dat_q, s_dat_d, cap_dat_q, cap_dat_d;

    state_e         state_q, state_d;
    logic [RIW-1:0] ptr_q, ptr_d;
    logic [DW-1:0]  regs_q [NREG];
    logic [DW-1:0]  regs_d [NREG];
    logic           cmd_vld_q, cmd_vld_d, reg_we_q, reg_we_d, seq_done_q, seq_done_d;
    logic           seq_err_q, seq_err_d;
    logic [DW-1:0]  cmd_code_q, cmd_code_d, reg_wdata_q, reg_wdata_d;
    logic [RIW-1:0] reg_idx_q, reg_idx_d;
    logic           ev;

    always_comb begin
        wr_s1_d   = ~host.ce_x & ~host.wr_x;
        s_wr_d    = wr_s1_q;
        wr_prev_d = s_wr_q;
        a0_s1_d   = host.a0;
        s_a0_d    = a0_s1_q;
        dat_s1_d  = host.dat;
        s_dat_d   = dat_s1_q;
        // Capture tracks the bus while the strobe is active so the event sees the last value.
        cap_a0_d  = s_wr_q ? s_a0_q  : cap_a0_q;
        cap_dat_d = s_wr_q ? s_dat_q : cap_dat_q;
    end

    assign ev = ~s_wr_q & wr_prev_q;

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        regs_d      = regs_q;
        cmd_vld_d   = 1'b0;
        reg_we_d    = 1'b0;
        seq_done_d  = 1'b0;
        seq_err_d   = seq_err_q;
        cmd_code_d  = cmd_code_q;
        reg_idx_d   = reg_idx_q;
        reg_wdata_d = reg_wdata_q;
        if (ev) begin
            if (cap_a0_q) begin
                cmd_code_d = cap_dat_q;
                seq_err_d  = 1'b0;
                ptr_d      = '0;
                if (cap_dat_q == CMD_BASE) begin
                    state_d = StParam;
                end else begin
                    state_d   = StIdle;
                    cmd_vld_d = 1'b1;
                end
            end else begin
                unique case (state_q)
                    StParam: begin
                        regs_d[ptr_q] = cap_dat_q;
                        reg_we_d      = 1'b1;
                        reg_idx_d     = ptr_q;
                        reg_wdata_d   = cap_dat_q;
                        if (ptr_q == RIW'(NREG - 1)) begin
                            seq_done_d = 1'b1;
                            state_d    = StIdle;
                            ptr_d      = '0;
                        end else begin
                            ptr_d = ptr_q + RIW'(1);
                        end
                    end
                    default: seq_err_d = 1'b1;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_s1_q     <= 1'b0;
            s_wr_q      <= 1'b0;
            wr_prev_q   <= 1'b0;
            a0_s1_q     <= 1'b0;
            s_a0_q      <= 1'b0;
            cap_a0_q    <= 1'b0;
            dat_s1_q    <= '0;
            s_dat_q     <= '0;
            cap_dat_q   <= '0;
            state_q     <= StIdle;
            ptr_q       <= '0;
            regs_q      <= '{default: '0};
            cmd_vld_q   <= 1'b0;
            reg_we_q    <= 1'b0;
            seq_done_q  <= 1'b0;
            seq_err_q   <= 1'b0;
            cmd_code_q  <= '0;
            reg_idx_q   <= '0;
            reg_wdata_q <= '0;
        end else begin
            wr_s1_q     <= wr_s1_d;
            s_wr_q      <= s_wr_d;
            wr_prev_q   <= wr_prev_d;
            a0_s1_q     <= a0_s1_d;
            s_a0_q      <= s_a0_d;
            cap_a0_q    <= cap_a0_d;
            dat_s1_q    <= dat_s1_d;
            s_dat_q     <= s_dat_d;
            cap_dat_q   <= cap_dat_d;
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            regs_q      <= regs_d;
            cmd_vld_q   <= cmd_vld_d;
            reg_we_q    <= reg_we_d;
            seq_done_q  <= seq_done_d;
            seq_err_q   <= seq_err_d;
            cmd_code_q  <= cmd_code_d;
            reg_idx_q   <= reg_idx_d;
            reg_wdata_q <= reg_wdata_d;
        end
    end

    assign cmd_vld   = cmd_vld_q;
    assign cmd_code  = cmd_code_q;
    assign reg_we    = reg_we_q;
    assign reg_idx   = reg_idx_q;
    assign reg_wdata = reg_wdata_q;
    assign seq_done  = seq_done_q;
    assign seq_err   = seq_err_q;

    for (genvar i = 0; i < NREG; i++) begin : g_flat
        assign reg_flat[i*DW +: DW] = regs_q[i];
    end

endmodule

// File: doc/host_param_seq.md
# host_param_seq

Parametrised host command/parameter sequencer for the LCD controller host port. It synchronises the asynchronous 8080-style write bus (ce_x, a0, wr_x, dat) into the core clock domain. It decodes command writes (a0=1) and parameter writes (a0=0), auto-increments a parameter pointer after a base command, and holds a NREG-deep register file that feeds the display timing blocks. It sits between the host pins and the timing/register consumers, which read the flattened register bus.

## Interface
- DW, 8, data bus and register width
- NREG, 8, number of parameter registers (2..16)
- RIW, 3, register index width; must satisfy 2**RIW >= NREG
- CMD_BASE, 8'h40, command code that opens a parameter sequence
- clk  in  1  core clock
- rst  in  1  asynchronous reset, active-high
- ce_x  in  1  host chip select, active low, asynchronous to clk
- a0  in  1  host address: 1 = command, 0 = parameter
- wr_x  in  1  host write strobe, active low, asynchronous to clk
- dat  in  DW  host write data
- cmd_vld  out  1  one-cycle pulse: non-base command accepted
- cmd_code  out  DW  last accepted command code
- reg_we  out  1  one-cycle pulse: parameter register written
- reg_idx  out  RIW  index of the register written with reg_we
- reg_wdata  out  DW  data written with reg_we
- seq_done  out  1  one-cycle pulse: register NREG-1 written
- seq_err  out  1  sticky: parameter write received in IDLE
- reg_flat  out  NREG*DW  register file; reg[i] at bits [i*DW +: DW]

## Operation
- Sync: wr_en = ~ce_x & ~wr_x, a0 and dat each pass through 2-flop synchronisers every clk. Stage-2 values are s_wr, s_a0, s_dat.
- Capture: while s_wr=1, latch s_a0/s_dat into cap_a0/cap_dat each cycle. The write event ev is the falling edge of s_wr (s_wr=0, previous=1). It uses cap values from the last active cycle.
- FSM states: IDLE, PARAM. Pointer ptr is RIW bits wide.
- ev with cap_a0=1, cap_dat==CMD_BASE: go to PARAM, ptr<=0, clear seq_err, cmd_code<=cap_dat. No cmd_vld is issued.
- ev with cap_a0=1, other code: cmd_code<=cap_dat, cmd_vld pulse, clear seq_err. If in PARAM, abort to IDLE; registers already written stay written.
- ev with cap_a0=0 in PARAM: reg[ptr]<=cap_dat, reg_we pulse with reg_idx=ptr and reg_wdata=cap_dat.
  - If ptr==NREG-1: seq_done pulse, go to IDLE, ptr<=0.
  - Otherwise ptr<=ptr+1.
- ev with cap_a0=0 in IDLE: no register change, seq_err<=1 (sticky until the next command ev or reset).
- A new CMD_BASE received while in PARAM restarts the sequence at ptr=0.
- Reset (any time, including mid-sequence): state IDLE, ptr=0, all reg[i]=0, cmd_code=0, all pulses 0, seq_err=0, synchroniser and capture flops 0.

## Timing
- Latency: ev, and with it cmd_vld/reg_we/seq_done, is registered. The pulse is high in the 3rd or 4th clk rising edge after the wr_x/ce_x deassert edge; the spread depends on synchronisation phase. Pulses last exactly 1 clk.
- reg_flat, cmd_code and seq_err update on the same edge as their pulse.
- Host requirements: strobe low for at least 3 clk; high for at least 3 clk between writes; dat/a0 stable throughout the strobe low time.
- A strobe shorter than 2 clk may be missed. This is not an error condition, and no output is generated.
- reg_idx/reg_wdata hold their last values between pulses.

## Test plan
- Reset: assert rst mid-sequence, after 3 params -> all outputs 0, reg_flat=0, state IDLE. The next param write sets seq_err=1.
- Full sequence: cmd 8'h40, then params 8'h10..8'h17 -> 8 reg_we pulses, reg_idx 0..7. seq_done coincides with idx 7. reg_flat = 64'h1716151413121110.
- Other command: cmd 8'h59 -> single cmd_vld, cmd_code=8'h59, no reg_we, state IDLE.
- Abort/restart: cmd 8'h40, params 8'hA0, 8'hA1, cmd 8'h40, param 8'hB0 -> reg[0]=8'hB0, reg[1]=8'hA1, next reg_idx=1.
- Stray param: param 8'h55 in IDLE -> no reg_we, seq_err=1. Then cmd 8'h40 -> seq_err=0.
- Strobe timing: 3-clk-low strobes at random phase, back-to-back, with 3-clk gaps -> every write is decoded exactly once. Latency is 3–4 clk.
